// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle into the register file and
// stalls MEM while a load response is outstanding. Define WB_PERF_EN to add retire_cnt.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_wen,
  input  logic [4:0]       mem_waddr,
  input  logic [31:0]      mem_alu_res,
  input  logic             mem_is_load,
  input  logic [2:0]       mem_load_type,
  input  logic [1:0]       mem_addr_lo,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
`ifdef WB_PERF_EN
  output logic [CNT_W-1:0] retire_cnt,
`endif
  output logic             wb_busy,
  output logic             wb_err,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;

  logic        accept;
  logic        alu_accept;
  logic        load_accept;
  logic        resp_take;
  logic        load_bad;

  logic        ld_wen_q, ld_wen_d;
  logic [4:0]  ld_waddr_q, ld_waddr_d;
  logic [2:0]  ld_type_q, ld_type_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        ld_err_q, ld_err_d;

  logic        rf_wen_q, rf_wen_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        wb_err_q, wb_err_d;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_accept) state_d = S_WAIT;
      S_WAIT:  if (dmem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (state only, never mem_valid) ----------------
  always_comb begin
    mem_ready = (state_q == S_IDLE);
    wb_busy   = (state_q == S_WAIT);
  end

  assign accept      = mem_valid & mem_ready;
  assign alu_accept  = accept & ~mem_is_load;
  assign load_accept = accept & mem_is_load;
  assign resp_take   = wb_busy & dmem_rvalid;

  // Alignment and encoding are judged at accept time, from the MEM-side fields.
  always_comb begin
    load_bad = 1'b0;
    case (mem_load_type)
      3'b000, 3'b100: load_bad = 1'b0;
      3'b001, 3'b101: load_bad = mem_addr_lo[0];
      3'b010:         load_bad = |mem_addr_lo;
      default:        load_bad = 1'b1;
    endcase
  end

  always_comb begin
    ld_wen_d   = ld_wen_q;
    ld_waddr_d = ld_waddr_q;
    ld_type_d  = ld_type_q;
    ld_lo_d    = ld_lo_q;
    ld_err_d   = ld_err_q;
    if (load_accept) begin
      ld_wen_d   = mem_wen;
      ld_waddr_d = mem_waddr;
      ld_type_d  = mem_load_type;
      ld_lo_d    = mem_addr_lo;
      ld_err_d   = load_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_wen_q   <= 1'b0;
      ld_waddr_q <= 5'd0;
      ld_type_q  <= 3'd0;
      ld_lo_q    <= 2'd0;
      ld_err_q   <= 1'b0;
    end else begin
      ld_wen_q   <= ld_wen_d;
      ld_waddr_q <= ld_waddr_d;
      ld_type_q  <= ld_type_d;
      ld_lo_q    <= ld_lo_d;
      ld_err_q   <= ld_err_d;
    end
  end

  // Lane select and extension of the returned word.
  always_comb begin
    sel_byte = dmem_rdata[7:0];
    case (ld_lo_q)
      2'd0:    sel_byte = dmem_rdata[7:0];
      2'd1:    sel_byte = dmem_rdata[15:8];
      2'd2:    sel_byte = dmem_rdata[23:16];
      default: sel_byte = dmem_rdata[31:24];
    endcase
    sel_half = ld_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_type_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Register-file port: x0 and errored loads never raise rf_wen.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_err_d   = 1'b0;
    if (alu_accept) begin
      rf_wen_d   = mem_wen & (mem_waddr != 5'd0);
      rf_waddr_d = mem_waddr;
      rf_wdata_d = mem_alu_res;
    end else if (load_accept) begin
      wb_err_d   = load_bad;
    end else if (resp_take) begin
      rf_wen_d   = ld_wen_q & (ld_waddr_q != 5'd0) & ~ld_err_q;
      rf_waddr_d = ld_waddr_q;
      rf_wdata_d = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      wb_err_q   <= 1'b0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_err   = wb_err_q;

`ifdef WB_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Every completion counts, including x0 targets and errored loads.
  always_comb begin
    cnt_d = cnt_q;
    if (alu_accept | resp_take) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_wb_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_wen = 1'b0;
  logic [4:0]  mem_waddr = 5'd0;
  logic [31:0] mem_alu_res = 32'd0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_load_type = 3'd0;
  logic [1:0]  mem_addr_lo = 2'd0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_busy;
  logic        wb_err;
`ifdef WB_PERF_EN
  logic [CW-1:0] retire_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_wen      (mem_wen),
    .mem_waddr    (mem_waddr),
    .mem_alu_res  (mem_alu_res),
    .mem_is_load  (mem_is_load),
    .mem_load_type(mem_load_type),
    .mem_addr_lo  (mem_addr_lo),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
`ifdef WB_PERF_EN
    .retire_cnt   (retire_cnt),
`endif
    .wb_busy      (wb_busy),
    .wb_err       (wb_err),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_bad(input logic [2:0] t, input logic [1:0] lo);
    int sz;
    case (t)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    return 1'b1;
    endcase
    return (int'(lo) % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] v;
    case (t)
      3'd0, 3'd4: begin
        v = (w >> (8 * int'(lo))) & 32'h0000_00FF;
        if (t == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (int'(lo) / 2))) & 32'h0000_FFFF;
        if (t == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  bit          m_busy = 1'b0;
  logic [4:0]  p_waddr;
  bit          p_wen, p_bad;
  logic [2:0]  p_type;
  logic [1:0]  p_lo;
  bit          e_wen, e_err, known;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  logic [CW-1:0] e_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; e_wen = 1'b0; e_err = 1'b0; known = 1'b1;
      e_waddr = 5'd0; e_wdata = 32'd0; e_cnt = '0;
    end else begin
      e_wen = 1'b0;
      e_err = 1'b0;
      if (!m_busy) begin
        if (mem_valid && !mem_is_load) begin
          e_wen = mem_wen && (mem_waddr != 5'd0);
          e_waddr = mem_waddr;
          e_wdata = mem_alu_res;
          known = 1'b1;
          e_cnt = e_cnt + 1'b1;
          $display("retire alu  x%0d wen=%0b data=%h", mem_waddr, e_wen, mem_alu_res);
        end else if (mem_valid) begin
          p_waddr = mem_waddr; p_wen = mem_wen; p_type = mem_load_type; p_lo = mem_addr_lo;
          p_bad = model_bad(mem_load_type, mem_addr_lo);
          e_err = p_bad;
          m_busy = 1'b1;
        end
      end else if (dmem_rvalid) begin
        m_busy = 1'b0;
        e_cnt = e_cnt + 1'b1;
        e_wen = p_wen && (p_waddr != 5'd0) && !p_bad;
        if (p_bad) begin
          known = 1'b0;
        end else begin
          known = 1'b1;
          e_waddr = p_waddr;
          e_wdata = model_load(p_type, p_lo, dmem_rdata);
        end
        $display("retire load x%0d wen=%0b bad=%0b data=%h", p_waddr, e_wen, p_bad,
                 p_bad ? 32'd0 : e_wdata);
      end
    end
    #1;
    chk("m_rf_wen", 32'(rf_wen), 32'(e_wen));
    chk("m_wb_err", 32'(wb_err), 32'(e_err));
    chk("m_mem_ready", 32'(mem_ready), 32'(!m_busy));
    chk("m_wb_busy", 32'(wb_busy), 32'(m_busy));
    if (known) begin
      chk("m_rf_waddr", 32'(rf_waddr), 32'(e_waddr));
      chk("m_rf_wdata", rf_wdata, e_wdata);
    end
`ifdef WB_PERF_EN
    chk("m_retire_cnt", 32'(retire_cnt), 32'(e_cnt));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    mem_valid = 1'b0; mem_is_load = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic alu_op(input logic [4:0] a, input logic [31:0] d);
    mem_valid = 1'b1; mem_is_load = 1'b0; mem_wen = 1'b1; mem_waddr = a; mem_alu_res = d;
  endtask

  task automatic load_op(input logic [4:0] a, input logic [2:0] t, input logic [1:0] lo);
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_wen = 1'b1; mem_waddr = a;
    mem_load_type = t; mem_addr_lo = lo;
  endtask

  task automatic load_case(input string nm, input logic [2:0] t, input logic [31:0] exp);
    load_op(5'd9, t, 2'd2);
    tick();
    chk({nm, "_ready_wait0"}, 32'(mem_ready), 32'd0);
    idle_in();
    tick();
    chk({nm, "_ready_wait1"}, 32'(mem_ready), 32'd0);
    tick();
    chk({nm, "_ready_wait2"}, 32'(mem_ready), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
    tick();
    chk({nm, "_wen"}, 32'(rf_wen), 32'd1);
    chk({nm, "_waddr"}, 32'(rf_waddr), 32'd9);
    chk({nm, "_wdata"}, rf_wdata, exp);
    chk({nm, "_ready_back"}, 32'(mem_ready), 32'd1);
    dmem_rvalid = 1'b0;
    $display("load %s done data=%h", nm, rf_wdata);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_wb_busy", 32'(wb_busy), 32'd0);
`ifdef WB_PERF_EN
    chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
`endif
    rst = 1'b0;

    alu_op(5'd5, 32'h1234_5678);
    tick();
    chk("alu_wen", 32'(rf_wen), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    idle_in();
    tick();
    chk("alu_wen_drop", 32'(rf_wen), 32'd0);
    $display("alu x5 done");

    load_case("lb", 3'b000, 32'hFFFF_FF80);
    load_case("lbu", 3'b100, 32'h0000_0080);

    load_op(5'd11, 3'b001, 2'd1);
    tick();
    chk("lh_mis_err", 32'(wb_err), 32'd1);
    chk("lh_mis_wen0", 32'(rf_wen), 32'd0);
    idle_in();
    tick();
    chk("lh_mis_err_drop", 32'(wb_err), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("lh_mis_no_wen", 32'(rf_wen), 32'd0);
    chk("lh_mis_ready", 32'(mem_ready), 32'd1);
    dmem_rvalid = 1'b0;
    $display("misaligned lh done");

    alu_op(5'd0, 32'h0000_AAAA);
    tick();
    chk("x0_wen", 32'(rf_wen), 32'd0);
    chk("x0_wdata", rf_wdata, 32'h0000_AAAA);
    alu_op(5'd7, 32'h7777_0007);
    tick();
    chk("x7_wen", 32'(rf_wen), 32'd1);
    chk("x7_waddr", 32'(rf_waddr), 32'd7);
    chk("x7_wdata", rf_wdata, 32'h7777_0007);
    idle_in();
    tick();
    $display("x0/x7 back-to-back done");

    load_op(5'd12, 3'b010, 2'd0);
    tick();
    chk("rstw_busy", 32'(wb_busy), 32'd1);
    idle_in();
    rst = 1'b1;
    #1;
    chk("rstw_ready_async", 32'(mem_ready), 32'd1);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    chk("rstw_no_wen", 32'(rf_wen), 32'd0);
    chk("rstw_ready", 32'(mem_ready), 32'd1);
    dmem_rvalid = 1'b0;
    $display("reset in wait done");

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      alu_op(5'd3, 32'(i));
      tick();
    end
    idle_in();
    tick();
`ifdef WB_PERF_EN
    chk("perf_wrap", 32'(retire_cnt), 32'd1);
`endif
    $display("17 alu ops done");

    for (int i = 0; i < 3000; i++) begin
      mem_valid     = ($urandom_range(0, 9) < 7);
      mem_is_load   = ($urandom_range(0, 9) < 3);
      mem_wen       = ($urandom_range(0, 9) < 8);
      mem_waddr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      mem_alu_res   = $urandom;
      mem_load_type = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && mem_load_type != 3'd2) mem_load_type[2] = 1'b1;
      mem_addr_lo   = 2'($urandom);
      dmem_rvalid   = ($urandom_range(0, 9) < 4);
      dmem_rdata    = $urandom;
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
